// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to a req/gnt memory port
// and buffers returned words with their PCs in a small FIFO for a valid/ready consumer.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W  = DEPTH[CW:0];
  localparam logic [CW-1:0] DEPTH_C  = DEPTH[CW-1:0];
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rpc_q, rpc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;

  logic [31:0]   buf_instr_q [DEPTH];
  logic [31:0]   buf_pc_q    [DEPTH];

  logic [CW:0]   credit_used;
  logic          grant;
  logic          have_drop;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_tgt;
  logic          unused_pc_lsbs;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + PW'(1);
  endfunction

  // Credit is taken from registered state only, so a same-cycle pop never frees a slot early.
  assign credit_used = {1'b0, cnt_q} + {1'b0, outst_q};
  assign imem_req    = !rst && !redirect && (credit_used < DEPTH_W);
  assign imem_addr   = pc_q;
  assign grant       = imem_req && imem_gnt;

  assign have_drop   = (drop_q != '0);
  assign resp_drop   = imem_rvalid && (have_drop || redirect);
  assign push        = imem_rvalid && !resp_drop;

  assign out_valid   = (cnt_q != '0);
  assign pop         = out_valid && out_ready && !redirect;
  assign out_instr   = out_valid ? buf_instr_q[head_q] : '0;
  assign out_pc      = out_valid ? buf_pc_q[head_q]    : '0;

  assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  always_comb begin
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    head_d  = head_q;
    tail_d  = tail_q;
    outst_d = outst_q + CW'(grant) - CW'(imem_rvalid);
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the abandoned path.
      pc_d   = redirect_tgt;
      rpc_d  = redirect_tgt;
      cnt_d  = '0;
      head_d = '0;
      tail_d = '0;
      drop_d = outst_q - CW'(imem_rvalid);
    end else begin
      if (grant) pc_d = pc_q + 32'd4;
      if (push) begin
        rpc_d  = rpc_q + 32'd4;
        tail_d = next_idx(tail_q);
      end
      if (pop) head_d = next_idx(head_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if (imem_rvalid && have_drop) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      rpc_q   <= RESET_PC;
      cnt_q   <= '0;
      outst_q <= '0;
      drop_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Storage carries no reset; out_valid gates what is visible downstream.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[tail_q] <= imem_rdata;
      buf_pc_q[tail_q]    <= rpc_q;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && (cnt_q == DEPTH_C)));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against a
// program-order reference (after each redirect the stream is target, target+4, ...).
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int lat_min = 0;
  int lat_max = 0;

  pend_t       pend[$];
  out_t        out_log[$];
  logic [31:0] fetch_log[$];

  logic        s_req, s_ovalid, s_rvalid;
  logic [31:0] s_addr, s_opc, s_oinstr;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ifunc(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: memory model drives the response, outputs are sampled mid-cycle,
  // and grants / accepted outputs are logged for the tests to inspect.
  task automatic cycle();
    pend_t p;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ifunc(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_rvalid = imem_rvalid;
    s_ovalid = out_valid; s_opc = out_pc; s_oinstr = out_instr;
    if (imem_req && imem_gnt) begin
      fetch_log.push_back(imem_addr);
      p.addr = imem_addr;
      p.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
      pend.push_back(p);
    end
    if (imem_rvalid) void'(pend.pop_front());
    if (out_valid && out_ready && !redirect) begin
      out_t o;
      o.pc = out_pc; o.instr = out_instr;
      out_log.push_back(o);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    lat_min = 0; lat_max = 0;
    pend.delete(); out_log.delete(); fetch_log.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b, expected 0", imem_req); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    tests_run++; if (out_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_out_pc: got %h, expected 0", out_pc); end
    tests_run++; if (out_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_out_instr: got %h, expected 0", out_instr); end
    rst = 1'b0;
    cycle();
    tests_run++; if (s_req !== 1'b1) begin tests_failed++; $display("FAIL first_req: got %b, expected 1", s_req); end
    tests_run++; if (s_addr !== RESET_PC) begin tests_failed++; $display("FAIL first_addr: got %h, expected %h", s_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    logic ov[10];
    logic [31:0] opc[10];
    logic [31:0] e;
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      ov[k] = s_ovalid; opc[k] = s_opc;
    end
    tests_run++; if (ov[0] !== 1'b0 || ov[1] !== 1'b0) begin tests_failed++; $display("FAIL stream_latency_early: got %b%b, expected 00", ov[0], ov[1]); end
    tests_run++; if (ov[2] !== 1'b1 || opc[2] !== RESET_PC) begin tests_failed++; $display("FAIL stream_first_out: got v=%b pc=%h, expected v=1 pc=%h", ov[2], opc[2], RESET_PC); end
    tests_run++; if (ov[3] !== 1'b1 || opc[3] !== RESET_PC + 32'd4) begin tests_failed++; $display("FAIL stream_second_out: got v=%b pc=%h, expected v=1 pc=%h", ov[3], opc[3], RESET_PC + 32'd4); end
    tests_run++;
    if (out_log.size() < 4) begin tests_failed++; $display("FAIL stream_count: got %0d, expected >=4", out_log.size()); end
    else for (int i = 0; i < 4; i++) begin
      e = RESET_PC + 32'(4 * i);
      tests_run++;
      if (out_log[i].pc !== e || out_log[i].instr !== ifunc(e)) begin
        tests_failed++; $display("FAIL stream_item%0d: got pc=%h instr=%h, expected pc=%h instr=%h", i, out_log[i].pc, out_log[i].instr, e, ifunc(e));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b0;
    repeat (6) cycle();
    tests_run++; if (s_req !== 1'b0) begin tests_failed++; $display("FAIL bp_req_drop: got %b, expected 0", s_req); end
    tests_run++; if (fetch_log.size() != DEPTH) begin tests_failed++; $display("FAIL bp_grants: got %0d, expected %0d", fetch_log.size(), DEPTH); end
    tests_run++; if (s_ovalid !== 1'b1 || s_opc !== RESET_PC) begin tests_failed++; $display("FAIL bp_head: got v=%b pc=%h, expected v=1 pc=%h", s_ovalid, s_opc, RESET_PC); end
    out_ready = 1'b1;
    repeat (12) cycle();
    tests_run++;
    if (out_log.size() < 6) begin tests_failed++; $display("FAIL bp_count: got %0d, expected >=6", out_log.size()); end
    else for (int i = 0; i < 6; i++) begin
      e = RESET_PC + 32'(4 * i);
      tests_run++;
      if (out_log[i].pc !== e || out_log[i].instr !== ifunc(e)) begin
        tests_failed++; $display("FAIL bp_item%0d: got pc=%h instr=%h, expected pc=%h", i, out_log[i].pc, out_log[i].instr, e);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b1; lat_min = 3; lat_max = 3;
    cycle(); cycle();
    tests_run++; if (pend.size() != 2) begin tests_failed++; $display("FAIL rdi_inflight: got %0d, expected 2", pend.size()); end
    redirect = 1'b1; redirect_pc = 32'h0000_0101;
    cycle();
    tests_run++; if (s_req !== 1'b0) begin tests_failed++; $display("FAIL rdi_req_forced: got %b, expected 0", s_req); end
    redirect = 1'b0;
    cycle();
    tests_run++; if (s_addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL rdi_addr_next: got %h, expected 00000100", s_addr); end
    tests_run++; if (s_ovalid !== 1'b0) begin tests_failed++; $display("FAIL rdi_valid_next: got %b, expected 0", s_ovalid); end
    repeat (16) cycle();
    tests_run++;
    if (out_log.size() < 2) begin tests_failed++; $display("FAIL rdi_count: got %0d, expected >=2", out_log.size()); end
    else begin
      tests_run++; if (out_log[0].pc !== 32'h100 || out_log[0].instr !== ifunc(32'h100)) begin tests_failed++; $display("FAIL rdi_first: got pc=%h instr=%h, expected pc=00000100 instr=%h", out_log[0].pc, out_log[0].instr, ifunc(32'h100)); end
      tests_run++; if (out_log[1].pc !== 32'h104 || out_log[1].instr !== ifunc(32'h104)) begin tests_failed++; $display("FAIL rdi_second: got pc=%h instr=%h, expected pc=00000104", out_log[1].pc, out_log[1].instr); end
    end
  endtask

  task automatic test_redirect_rvalid();
    logic [31:0] tgt;
    tgt = 32'h2000_0040;
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b1;
    cycle(); cycle();
    redirect = 1'b1; redirect_pc = tgt | 32'h3;
    cycle();
    tests_run++; if (s_rvalid !== 1'b1 || s_ovalid !== 1'b1) begin tests_failed++; $display("FAIL rdv_setup: got rvalid=%b out_valid=%b, expected 1 1", s_rvalid, s_ovalid); end
    redirect = 1'b0;
    cycle();
    tests_run++; if (s_ovalid !== 1'b0) begin tests_failed++; $display("FAIL rdv_t1_valid: got %b, expected 0", s_ovalid); end
    tests_run++; if (s_req !== 1'b1 || s_addr !== tgt) begin tests_failed++; $display("FAIL rdv_t1_req: got req=%b addr=%h, expected req=1 addr=%h", s_req, s_addr, tgt); end
    cycle();
    tests_run++; if (s_ovalid !== 1'b0) begin tests_failed++; $display("FAIL rdv_t2_valid: got %b, expected 0", s_ovalid); end
    cycle();
    tests_run++; if (s_ovalid !== 1'b1 || s_opc !== tgt || s_oinstr !== ifunc(tgt)) begin tests_failed++; $display("FAIL rdv_t3_out: got v=%b pc=%h instr=%h, expected v=1 pc=%h", s_ovalid, s_opc, s_oinstr, tgt); end
    repeat (8) cycle();
    tests_run++;
    if (out_log.size() < 3) begin tests_failed++; $display("FAIL rdv_count: got %0d, expected >=3", out_log.size()); end
    else for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_log[i].pc !== tgt + 32'(4 * i) || out_log[i].instr !== ifunc(tgt + 32'(4 * i))) begin
        tests_failed++; $display("FAIL rdv_item%0d: got pc=%h, expected pc=%h", i, out_log[i].pc, tgt + 32'(4 * i));
      end
    end
  endtask

  task automatic test_gnt_stall();
    do_reset();
    imem_gnt = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      tests_run++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin tests_failed++; $display("FAIL stall_hold%0d: got req=%b addr=%h, expected req=1 addr=%h", k, s_req, s_addr, RESET_PC); end
    end
    imem_gnt = 1'b1;
    cycle();
    imem_gnt = 1'b0;
    cycle();
    tests_run++; if (s_addr !== RESET_PC + 32'd4) begin tests_failed++; $display("FAIL stall_advance: got %h, expected %h", s_addr, RESET_PC + 32'd4); end
    cycle();
    tests_run++; if (s_addr !== RESET_PC + 32'd4) begin tests_failed++; $display("FAIL stall_hold_after: got %h, expected %h", s_addr, RESET_PC + 32'd4); end
    tests_run++; if (fetch_log.size() != 1) begin tests_failed++; $display("FAIL stall_grants: got %0d, expected 1", fetch_log.size()); end
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b0;
    repeat (6) cycle();
    tests_run++; if (s_ovalid !== 1'b1) begin tests_failed++; $display("FAIL ar_full_setup: got %b, expected 1", s_ovalid); end
    #2;
    rst = 1'b1; imem_rvalid = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin tests_failed++; $display("FAIL ar_outputs: got v=%b pc=%h instr=%h, expected 0 0 0", out_valid, out_pc, out_instr); end
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL ar_req: got %b, expected 0", imem_req); end
    pend.delete(); out_log.delete(); fetch_log.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    cycle();
    tests_run++; if (s_req !== 1'b1 || s_addr !== RESET_PC) begin tests_failed++; $display("FAIL ar_restart: got req=%b addr=%h, expected req=1 addr=%h", s_req, s_addr, RESET_PC); end
    repeat (8) cycle();
    tests_run++;
    if (out_log.size() < 2) begin tests_failed++; $display("FAIL ar_count: got %0d, expected >=2", out_log.size()); end
    else begin
      tests_run++; if (out_log[0].pc !== RESET_PC || out_log[1].pc !== RESET_PC + 32'd4) begin tests_failed++; $display("FAIL ar_stream: got %h %h, expected %h %h", out_log[0].pc, out_log[1].pc, RESET_PC, RESET_PC + 32'd4); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] base, e;
    base = 32'hFFFF_FFF8;
    do_reset();
    imem_gnt = 1'b1; out_ready = 1'b1;
    redirect = 1'b1; redirect_pc = base;
    cycle();
    redirect = 1'b0;
    repeat (14) cycle();
    tests_run++;
    if (fetch_log.size() < 4 || out_log.size() < 4) begin tests_failed++; $display("FAIL wrap_count: got fetch=%0d out=%0d, expected >=4 each", fetch_log.size(), out_log.size()); end
    else for (int i = 0; i < 4; i++) begin
      e = base + 32'(4 * i);
      tests_run++;
      if (fetch_log[i] !== e || out_log[i].pc !== e || out_log[i].instr !== ifunc(e)) begin
        tests_failed++; $display("FAIL wrap_item%0d: got addr=%h pc=%h, expected %h", i, fetch_log[i], out_log[i].pc, e);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_out, exp_fetch, tgt, a;
    logic prev_redir;
    out_t o;
    int n_tail;
    do_reset();
    exp_out = RESET_PC; exp_fetch = RESET_PC; prev_redir = 1'b0; n_tail = 0;
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      imem_gnt  = ($urandom_range(3) != 0);
      out_ready = (i >= 2800) || ($urandom_range(3) != 0);
      redirect  = (i < 2800) && !prev_redir && ($urandom_range(29) == 0);
      tgt = $urandom;
      redirect_pc = tgt;
      cycle();
      if (redirect) begin
        tests_run++; if (s_req !== 1'b0) begin tests_failed++; $display("FAIL rnd_req_on_redirect: cycle %0d got %b, expected 0", i, s_req); end
      end
      if (!s_ovalid) begin
        tests_run++; if (s_opc !== 32'h0 || s_oinstr !== 32'h0) begin tests_failed++; $display("FAIL rnd_idle_zero: cycle %0d got pc=%h instr=%h, expected 0 0", i, s_opc, s_oinstr); end
      end
      while (fetch_log.size() > 0) begin
        a = fetch_log.pop_front();
        tests_run++; if (a !== exp_fetch) begin tests_failed++; $display("FAIL rnd_fetch_addr: cycle %0d got %h, expected %h", i, a, exp_fetch); end
        exp_fetch = exp_fetch + 32'd4;
      end
      while (out_log.size() > 0) begin
        o = out_log.pop_front();
        if (i >= 2800) n_tail++;
        tests_run++; if (o.pc !== exp_out || o.instr !== ifunc(exp_out)) begin tests_failed++; $display("FAIL rnd_out: cycle %0d got pc=%h instr=%h, expected pc=%h instr=%h", i, o.pc, o.instr, exp_out, ifunc(exp_out)); end
        exp_out = exp_out + 32'd4;
      end
      if (redirect) begin
        exp_out   = {tgt[31:2], 2'b00};
        exp_fetch = {tgt[31:2], 2'b00};
      end
      prev_redir = redirect;
    end
    redirect = 1'b0;
    tests_run++; if (n_tail < 30) begin tests_failed++; $display("FAIL rnd_progress: got %0d outputs in tail, expected >=30", n_tail); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rvalid();
    test_gnt_stall();
    test_async_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
